// File: rtl/timestamp_pkg.sv
// Shared types and sizing helpers for the event timestamper and the record packer.
package timestamp_pkg;

  localparam int SEQ_W = 16;

  typedef enum logic {
    IDLE,
    SEND
  } packer_state_e;

  // Bytes on the wire for one record: optional sequence prefix, byte-padded id, three timestamps.
  function automatic int rec_bytes(input int id_w, input int ts_w, input bit seq_en);
    return (seq_en ? SEQ_W / 8 : 0) + (id_w + 7) / 8 + 3 * (ts_w / 8);
  endfunction

endpackage

// File: rtl/timestamp_record_packer_record_fifo.sv
// Small synchronous record FIFO with a combinational head read.
module record_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  // A push into a full FIFO is dropped even when a pop frees a slot in the same cycle.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/timestamp_record_packer.sv
// Buffers timestamp records and serializes them MSB-first onto a byte stream with a per-record last flag.
// Optional TS_PACKER_SEQ_EN prefixes every record with a 16-bit big-endian sequence number.
module timestamp_record_packer
  import timestamp_pkg::*;
#(
  parameter int ID_W       = 4,
  parameter int TS_W       = 64,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [ID_W-1:0] in_id,
  input  logic [TS_W-1:0] in_start_ts,
  input  logic [TS_W-1:0] in_end_ts,
  input  logic [TS_W-1:0] in_ts,
  output logic            m_valid,
  input  logic            m_ready,
  output logic [7:0]      m_data,
  output logic            m_last,
  output logic [31:0]     rec_sent
);

`ifdef TS_PACKER_SEQ_EN
  localparam bit SEQ_EN = 1'b1;
`else
  localparam bit SEQ_EN = 1'b0;
`endif

  localparam int ID_BYTES  = (ID_W + 7) / 8;
  localparam int REC_BYTES = rec_bytes(ID_W, TS_W, SEQ_EN);
  localparam int REC_W     = REC_BYTES * 8;
  localparam int CNT_W     = $clog2(REC_BYTES);
  localparam int FIFO_W    = ID_W + 3 * TS_W;

  if ((TS_W % 8) != 0) begin : g_ts_w_chk
    $error("timestamp_record_packer: TS_W must be a multiple of 8");
  end
  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_chk
    $error("timestamp_record_packer: FIFO_DEPTH must be a power of 2 and >= 2");
  end

  packer_state_e         state;
  logic [REC_W-1:0]      shift_reg;
  logic [CNT_W-1:0]      byte_cnt;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FIFO_W-1:0]     fifo_wdata;
  logic [FIFO_W-1:0]     fifo_rdata;
  logic                  push;
  logic                  pop;
  logic                  last_byte;
  logic [ID_BYTES*8-1:0] id_pad;
  logic [REC_W-1:0]      load_word;

  assign in_ready   = !fifo_full && !rst;
  assign push       = in_valid && in_ready;
  assign fifo_wdata = {in_id, in_start_ts, in_end_ts, in_ts};

  record_fifo #(
    .WIDTH (FIFO_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .wdata (fifo_wdata),
    .rdata (fifo_rdata)
  );

  always_comb begin
    id_pad = '0;
    id_pad[ID_W-1:0] = fifo_rdata[FIFO_W-1 -: ID_W];
  end

`ifdef TS_PACKER_SEQ_EN
  logic [SEQ_W-1:0] seq_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      seq_reg <= '0;
    end else if (pop) begin
      seq_reg <= seq_reg + SEQ_W'(1);
    end
  end

  assign load_word = {seq_reg, id_pad, fifo_rdata[3*TS_W-1:0]};
`else
  assign load_word = {id_pad, fifo_rdata[3*TS_W-1:0]};
`endif

  assign last_byte = (state == SEND) && (byte_cnt == CNT_W'(REC_BYTES - 1));
  // Reload on the final handshake so consecutive records leave without a bubble.
  assign pop       = !fifo_empty && ((state == IDLE) || (last_byte && m_ready));

  // The shift register is cleared whenever nothing is loaded, so m_data idles at zero.
  assign m_valid = (state == SEND);
  assign m_data  = shift_reg[REC_W-1 -: 8];
  assign m_last  = last_byte;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      shift_reg <= '0;
      byte_cnt  <= '0;
      rec_sent  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            shift_reg <= load_word;
            byte_cnt  <= '0;
            state     <= SEND;
          end
        end
        SEND: begin
          if (m_ready) begin
            if (last_byte) begin
              rec_sent <= rec_sent + 32'd1;
              byte_cnt <= '0;
              if (pop) begin
                shift_reg <= load_word;
              end else begin
                shift_reg <= '0;
                state     <= IDLE;
              end
            end else begin
              shift_reg <= {shift_reg[REC_W-9:0], 8'h00};
              byte_cnt  <= byte_cnt + CNT_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
